// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-committed arbiter sharing the async FIFO write port among N_REQ requesters.
// Everything runs in the write clock domain; wfull throttles beats combinationally.
module fifo_write_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned D_WIDTH = 8,
  parameter int unsigned BURST_W = 4
) (
  input  logic                       w_clk,
  input  logic                       w_rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*BURST_W-1:0]   req_len,
  input  logic [N_REQ*D_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]           req_ack,
  input  logic                       wfull,
  output logic                       w_inc,
  output logic [D_WIDTH-1:0]         wdata,
  output logic [N_REQ-1:0]           grant,
  output logic                       busy,
  output logic                       last
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_REQ - 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e               state_q, state_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [BURST_W-1:0]   cnt_q, cnt_d;

  logic                 found;
  logic [IdxW-1:0]      win_idx;
  logic                 arb_en;
  logic                 in_burst;
  logic                 beat;

  // Rotating priority search starting just after the previous winner.
  always_comb begin
    int idx;
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int off = 1; off <= int'(N_REQ); off++) begin
      idx = (int'(rr_ptr_q) + off) % int'(N_REQ);
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_idx = IdxW'(idx);
      end
    end
  end

  // While bursting, rr_ptr_q holds the owner index, so it doubles as the data mux select.
  always_comb begin
    in_burst = (state_q == StBurst);
    beat     = in_burst && !wfull && w_rst_n;
    w_inc    = beat;
    req_ack  = grant_q & {N_REQ{beat}};
    busy     = in_burst;
    grant    = grant_q;
    last     = in_burst && (cnt_q == '0);
    wdata    = '0;
    if (in_burst) begin
      wdata = req_data[int'(rr_ptr_q)*int'(D_WIDTH) +: D_WIDTH];
    end
  end

  assign arb_en = !in_burst || (beat && (cnt_q == '0));

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    if (arb_en) begin
      if (found) begin
        state_d          = StBurst;
        grant_d          = '0;
        grant_d[win_idx] = 1'b1;
        rr_ptr_d         = win_idx;
        cnt_d            = req_len[int'(win_idx)*int'(BURST_W) +: BURST_W];
      end else begin
        state_d = StIdle;
        grant_d = '0;
      end
    end else if (beat) begin
      cnt_d = cnt_q - BURST_W'(1);
    end
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= LastIdx;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model (owner, beats remaining, last winner).
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int D  = 8;
  localparam int BW = 4;

  logic            w_clk = 1'b0;
  logic            w_rst_n;
  logic [N-1:0]    req;
  logic [N*BW-1:0] req_len;
  logic [N*D-1:0]  req_data;
  logic            wfull;
  logic [N-1:0]    req_ack;
  logic            w_inc;
  logic [D-1:0]    wdata;
  logic [N-1:0]    grant;
  logic            busy;
  logic            last;

  fifo_write_arbiter #(
    .N_REQ  (N),
    .D_WIDTH(D),
    .BURST_W(BW)
  ) u_dut (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .req     (req),
    .req_len (req_len),
    .req_data(req_data),
    .req_ack (req_ack),
    .wfull   (wfull),
    .w_inc   (w_inc),
    .wdata   (wdata),
    .grant   (grant),
    .busy    (busy),
    .last    (last)
  );

  always #5 w_clk = ~w_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: owning requester (-1 when idle), beats still to send, most recent winner.
  int m_owner    = -1;
  int m_left     = 0;
  int m_last_win = N - 1;

  int st_beats, st_lasts, st_last_beat, st_ack0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_winner();
    for (int k = 1; k <= N; k++) begin
      int i = (m_last_win + k) % N;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  function automatic int len_of(input int i);
    return int'(req_len[i*BW +: BW]);
  endfunction

  function automatic int data_of(input int i);
    return int'(req_data[i*D +: D]);
  endfunction

  task automatic set_len(input int i, input int v);
    req_len[i*BW +: BW] = BW'(v);
  endtask

  // Called at a negedge with control inputs already applied; returns at the next negedge.
  task automatic cycle();
    logic        e_busy, e_winc;
    logic [31:0] e_grant, e_data;
    int          w;
    req_data = $urandom;
    #1;
    e_busy  = (m_owner >= 0);
    e_winc  = w_rst_n && e_busy && !wfull;
    e_grant = e_busy ? (32'(1) << m_owner) : 32'(0);
    e_data  = e_busy ? 32'(data_of(m_owner)) : 32'(0);
    check_eq("grant", 32'(grant), e_grant);
    check_eq("busy", 32'(busy), 32'(e_busy));
    check_eq("last", 32'(last), 32'(e_busy && (m_left == 1)));
    check_eq("w_inc", 32'(w_inc), 32'(e_winc));
    check_eq("req_ack", 32'(req_ack), e_winc ? e_grant : 32'(0));
    check_eq("wdata", 32'(wdata), e_data);
    if (w_inc) st_beats++;
    if (w_inc && last) begin
      st_lasts++;
      st_last_beat = st_beats;
    end
    if (req_ack == 4'b0001) st_ack0++;
    if (!w_rst_n) begin
      m_owner    = -1;
      m_left     = 0;
      m_last_win = N - 1;
    end else if (!e_busy || (e_winc && m_left == 1)) begin
      w = pick_winner();
      if (w >= 0) begin
        m_owner    = w;
        m_left     = len_of(w) + 1;
        m_last_win = w;
      end else begin
        m_owner = -1;
      end
    end else if (e_winc) begin
      m_left--;
    end
    @(posedge w_clk);
    @(negedge w_clk);
  endtask

  task automatic clear_stats();
    st_beats     = 0;
    st_lasts     = 0;
    st_last_beat = 0;
    st_ack0      = 0;
  endtask

  task automatic do_reset();
    req     = '0;
    w_rst_n = 1'b0;
    cycle();
    w_rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] stall_seq;
    w_rst_n  = 1'b0;
    req      = 4'b1111;
    req_len  = '0;
    req_data = '0;
    wfull    = 1'b0;
    clear_stats();
    @(negedge w_clk);

    // Reset held with all requesting; first grant after release goes to requester 0.
    for (int i = 0; i < 3; i++) cycle();
    w_rst_n = 1'b1;
    cycle();
    check_eq("rst_first_grant", 32'(grant), 32'h1);
    req = '0;
    while (busy) cycle();

    // Single 4-beat burst from requester 2.
    do_reset();
    req = 4'b0100;
    set_len(2, 3);
    cycle();
    check_eq("single_grant", 32'(grant), 32'h4);
    req = '0;
    clear_stats();
    for (int i = 0; i < 6; i++) cycle();
    check_eq("single_beats", 32'(st_beats), 32'd4);
    check_eq("single_lasts", 32'(st_lasts), 32'd1);
    check_eq("single_last_beat", 32'(st_last_beat), 32'd4);
    check_eq("single_busy_after", 32'(busy), 32'd0);

    // Round-robin rotation with single-beat bursts.
    do_reset();
    req_len = '0;
    req     = 4'b1111;
    cycle();
    for (int k = 0; k < 5; k++) begin
      check_eq("rr_grant", 32'(grant), 32'(1) << (k % 4));
      check_eq("rr_winc", 32'(w_inc), 32'd1);
      cycle();
    end
    req = '0;
    while (busy) cycle();

    // Two-cycle wfull stall inside a 6-beat burst.
    do_reset();
    req = 4'b0010;
    set_len(1, 5);
    cycle();
    req = '0;
    clear_stats();
    stall_seq = 8'b0000_0110;
    for (int i = 0; i < 8; i++) begin
      wfull = stall_seq[i];
      cycle();
    end
    wfull = 1'b0;
    check_eq("stall_beats", 32'(st_beats), 32'd6);
    check_eq("stall_lasts", 32'(st_lasts), 32'd1);
    check_eq("stall_last_beat", 32'(st_last_beat), 32'd6);

    // Committed 8-beat burst despite req drop, then immediate grant to requester 3.
    do_reset();
    req = 4'b0001;
    set_len(0, 7);
    cycle();
    clear_stats();
    for (int b = 0; b < 8; b++) begin
      if (b == 2) req[0] = 1'b0;
      if (b == 4) begin
        req[3] = 1'b1;
        set_len(3, 2);
      end
      cycle();
    end
    check_eq("commit_beats0", 32'(st_ack0), 32'd8);
    check_eq("b2b_grant", 32'(grant), 32'h8);
    req = '0;
    while (busy) cycle();

    // Reset during beat 3 of a 10-beat burst.
    do_reset();
    req = 4'b0001;
    set_len(0, 9);
    cycle();
    req = '0;
    cycle();
    cycle();
    req     = 4'b1111;
    w_rst_n = 1'b0;
    #1;
    check_eq("midrst_winc", 32'(w_inc), 32'd0);
    cycle();
    w_rst_n = 1'b1;
    check_eq("midrst_grant", 32'(grant), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    cycle();
    check_eq("midrst_regrant", 32'(grant), 32'h1);

    // Random traffic with stalls and occasional resets.
    for (int i = 0; i < 800; i++) begin
      req     = N'($urandom);
      req_len = (N*BW)'($urandom);
      wfull   = ($urandom_range(0, 3) == 0);
      w_rst_n = ($urandom_range(0, 63) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Write-side arbiter for the async FIFO. Shares the single FIFO write port (w_inc/wdata into the write-pointer/full logic and memory) between N_REQ requesters. Grants are round-robin and burst-oriented: a granted requester owns the port for a committed burst of 1..2^BURST_W beats. Beats are throttled by the FIFO's registered wfull flag. The block sits entirely in the write clock domain.

## Interface
- N_REQ, default 4: number of requesters (≥2).
- D_WIDTH, default 8: FIFO data width.
- BURST_W, default 4: burst length field width. Beats per burst = req_len + 1.

- w_clk  input  1  write-domain clock; all logic on posedge.
- w_rst_n  input  1  reset, synchronous, active-low.
- req  input  N_REQ  per-requester burst request, level.
- req_len  input  N_REQ*BURST_W  packed burst lengths; slice i = req_len[i*BURST_W +: BURST_W].
- req_data  input  N_REQ*D_WIDTH  packed write data; slice i = req_data[i*D_WIDTH +: D_WIDTH].
- req_ack  output  N_REQ  one-hot beat-accept strobe to the owner.
- wfull  input  1  FIFO full flag, registered in w_clk domain.
- w_inc  output  1  FIFO write enable.
- wdata  output  D_WIDTH  FIFO write data.
- grant  output  N_REQ  one-hot current owner; 0 when idle.
- busy  output  1  high while in BURST.
- last  output  1  high when the current beat is the final beat of the burst.

## Operation
- **State machine: IDLE, BURST.**
- **Registered state:** state, grant (one-hot), rr_ptr (index of the last winner), beat counter (BURST_W bits, remaining beats - 1).
- **Arbitration (combinational):** search for the first asserted req starting at index rr_ptr+1 mod N_REQ and wrapping around. The previous winner therefore has the lowest priority.
- **Arbitration occurs in two cases:**
  - in IDLE;
  - in BURST, on the cycle the final beat is accepted.
- **On a win:**
  - grant ← winner;
  - rr_ptr ← winner index;
  - counter ← req_len slice of the winner, sampled that cycle;
  - state ← BURST.
- **No win:** state ← IDLE and grant ← 0.
- **In BURST:**
  - w_inc = !wfull.
  - wdata = req_data slice of the owner (combinational mux).
  - req_ack = grant & {N_REQ{w_inc}}.
  - last = (counter == 0).
- **Beat accounting:**
  - Each accepted beat (w_inc = 1) with counter ≠ 0 decrements the counter.
  - An accepted beat with counter == 0 ends the burst and triggers re-arbitration.
- **Bursts are committed.**
  - Once granted, the owner's req is ignored until the burst ends.
  - Deasserting req mid-burst does not shorten the burst.
  - The requester must hold valid data until it sees its ack.
- **In IDLE:** w_inc = 0, req_ack = 0, last = 0, wdata = 0.
- **Reset gating:** w_inc and req_ack are forced to 0 combinationally whenever w_rst_n = 0, so no FIFO write occurs during reset.

## Timing
- **Reset** (w_rst_n low at a posedge). After that edge:
  - state = IDLE, grant = 0, busy = 0, last = 0, w_inc = 0, req_ack = 0, wdata = 0, counter = 0.
  - rr_ptr = N_REQ-1, so requester 0 has first priority.
- **Grant latency:** req sampled high in IDLE at edge t gives grant/busy high after edge t. The first w_inc is in cycle t+1 if wfull = 0. Minimum latency is 1 cycle.
- **Throughput:** one beat per cycle while wfull = 0. A burst of L+1 beats occupies exactly L+1 cycles with no stalls.
- **Back-to-back bursts:** when the final beat is accepted in cycle k and another req is pending, the new grant is valid in cycle k+1. There is no idle bubble.
- **wfull stalls:**
  - With wfull = 1 in a BURST cycle: w_inc = 0, req_ack = 0, and counter, grant and last hold.
  - The burst resumes on the first cycle with wfull = 0.
  - wfull → w_inc is a combinational path; wfull is already registered upstream.
- **Simultaneous requests:** exactly one grant, chosen by the rotation order from rr_ptr+1. grant is never more than one-hot.
- **Sole requester:** if the owner is the only requester at burst end, it is re-granted immediately.
- **Counter wrap:** req_len = 2^BURST_W - 1 gives a 2^BURST_W-beat burst. The counter never underflows.
- **Reset mid-burst:**
  - w_inc goes low in the same cycle as w_rst_n = 0.
  - The next edge returns all registers to reset values.
  - Remaining beats are discarded, and requesters must re-request.

## Test plan
- **Reset defaults:** hold w_rst_n = 0 for 3 cycles with req = 4'b1111. Required: w_inc, req_ack, grant and busy stay 0. After release, the first grant = 4'b0001.
- **Single burst:** req[2] = 1 with len = 3, wfull = 0. Required:
  - grant = 4'b0100 one cycle later;
  - w_inc high for exactly 4 cycles, with wdata tracking req_data slice 2;
  - last high on the 4th beat;
  - busy low afterwards.
- **Round-robin fairness:** req = 4'b1111, all len = 0, held high. Required:
  - grant sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles;
  - w_inc continuously high.
- **wfull stall:** req[1], len = 5; wfull = 1 on beats 2 and 3 for 2 cycles. Required:
  - w_inc and req_ack low for those 2 cycles, counter held;
  - 6 total accepted beats over 8 cycles;
  - last only on beat 6.
- **Committed burst with back-to-back grant:**
  - Stimulus: req[0], len = 7; drop req[0] after beat 2; req[3] rises mid-burst.
  - Required: all 8 beats from requester 0, then grant = 4'b1000 in the very next cycle.
- **Reset mid-burst:** assert w_rst_n = 0 during beat 3 of a len = 9 burst. Required:
  - w_inc low in that same cycle;
  - after the edge, grant = 0, state IDLE, and rr_ptr restored (next grant goes to the lowest-index requester).
